// File: rtl/ram_arbiter.sv
// Four-requester arbiter in front of a dual-port RAM. It clears the RAM two
// words per cycle after reset, then grants up to two accesses per cycle round-robin.
module ram_arbiter #(
  parameter int W = 8,
  parameter int M = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req,
  input  logic [3:0]     we_req,
  input  logic [4*W-1:0] addr_req,
  input  logic [4*W-1:0] wdata_req,
  output logic [3:0]     gnt,
  output logic [3:0]     rvalid,
  output logic [4*W-1:0] rdata,
  output logic           init_done,
  output logic [W-1:0]   addr_x,
  output logic [W-1:0]   addr_y,
  output logic [W-1:0]   data_x,
  output logic [W-1:0]   data_y,
  output logic           we_x,
  output logic           we_y,
  input  logic [W-1:0]   q_x,
  input  logic [W-1:0]   q_y
);

  // state  | meaning
  // S_INIT | clearing RAM, words cnt and cnt+1 written per cycle
  // S_RUN  | arbitration active
  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] cnt;
  logic [1:0]   ptr, ptr_nxt;
  logic         gx, gy;
  logic [1:0]   ix, iy, idx;
  logic [3:0]   rv_nxt;
  logic         tag_x_v, tag_y_v;
  logic [1:0]   tag_x_id, tag_y_id;

  // Scan from ptr; the second hit is skipped if it collides with port x on a write.
  always_comb begin
    gx  = 1'b0;
    gy  = 1'b0;
    ix  = 2'd0;
    iy  = 2'd0;
    idx = 2'd0;
    if (state == S_RUN) begin
      for (int k = 0; k < 4; k++) begin
        idx = ptr + 2'(k);
        if (req[idx]) begin
          if (!gx) begin
            gx = 1'b1;
            ix = idx;
          end else if (!gy &&
                       !((addr_req[idx*W +: W] == addr_req[ix*W +: W]) &&
                         (we_req[idx] || we_req[ix]))) begin
            gy = 1'b1;
            iy = idx;
          end
        end
      end
    end
  end

  always_comb begin
    gnt    = 4'd0;
    rv_nxt = 4'd0;
    addr_x = '0;
    addr_y = '0;
    data_x = '0;
    data_y = '0;
    we_x   = 1'b0;
    we_y   = 1'b0;
    if (state == S_INIT) begin
      we_x   = 1'b1;
      we_y   = 1'b1;
      addr_x = cnt;
      addr_y = cnt + W'(1);
    end else begin
      if (gx) begin
        gnt[ix]    = 1'b1;
        rv_nxt[ix] = ~we_req[ix];
        addr_x     = addr_req[ix*W +: W];
        data_x     = wdata_req[ix*W +: W];
        we_x       = we_req[ix];
      end
      if (gy) begin
        gnt[iy]    = 1'b1;
        rv_nxt[iy] = ~we_req[iy];
        addr_y     = addr_req[iy*W +: W];
        data_y     = wdata_req[iy*W +: W];
        we_y       = we_req[iy];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    if (state == S_INIT && cnt == W'(M-2)) state_nxt = S_RUN;
    if (gy)      ptr_nxt = iy + 2'd1;
    else if (gx) ptr_nxt = ix + 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_INIT;
      cnt      <= '0;
      ptr      <= 2'd0;
      tag_x_v  <= 1'b0;
      tag_y_v  <= 1'b0;
      tag_x_id <= 2'd0;
      tag_y_id <= 2'd0;
      rvalid   <= 4'd0;
    end else begin
      state    <= state_nxt;
      cnt      <= (state_nxt == S_INIT) ? cnt + W'(2) : '0;
      ptr      <= ptr_nxt;
      tag_x_v  <= gx && !we_req[ix];
      tag_y_v  <= gy && !we_req[iy];
      tag_x_id <= ix;
      tag_y_id <= iy;
      rvalid   <= rv_nxt;
    end
  end

  // Tags steer each port's registered read data back to the requester that owns it.
  always_comb begin
    rdata = '0;
    if (tag_x_v) rdata[tag_x_id*W +: W] = q_x;
    if (tag_y_v) rdata[tag_y_id*W +: W] = q_y;
  end

  assign init_done = (state == S_RUN);

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed vector table, reset and init
// sequences, then randomized traffic checked against a queue-based arbitration model.
module tb_ram_arbiter;
  localparam int W  = 8;
  localparam int M  = 16;
  localparam int AW = $clog2(M);

  logic           clk, rst;
  logic [3:0]     req, we_req, gnt, rvalid;
  logic [4*W-1:0] addr_req, wdata_req, rdata;
  logic           init_done, we_x, we_y;
  logic [W-1:0]   addr_x, addr_y, data_x, data_y, q_x, q_y;

  ram_arbiter #(.W(W), .M(M)) dut (
    .clk(clk), .rst(rst), .req(req), .we_req(we_req), .addr_req(addr_req),
    .wdata_req(wdata_req), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .init_done(init_done), .addr_x(addr_x), .addr_y(addr_y), .data_x(data_x),
    .data_y(data_y), .we_x(we_x), .we_y(we_y), .q_x(q_x), .q_y(q_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Dual-port RAM with registered read; ram_scrub fills it with a non-zero pattern.
  logic [W-1:0] ram [M];
  logic         ram_scrub;
  always @(posedge clk) begin
    if (ram_scrub) begin
      for (int j = 0; j < M; j++) ram[j] <= 8'hFF;
    end else begin
      if (we_x) ram[addr_x[AW-1:0]] <= data_x;
      if (we_y) ram[addr_y[AW-1:0]] <= data_y;
    end
    q_x <= ram[addr_x[AW-1:0]];
    q_y <= ram[addr_y[AW-1:0]];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]     req, we;
    logic [4*W-1:0] addr, wdata;
    logic [3:0]     e_gnt, e_rv;
    logic [4*W-1:0] e_rd;
  } vec_t;

  function automatic logic [4*W-1:0] pk(input int a3, input int a2, input int a1, input int a0);
    return {W'(a3), W'(a2), W'(a1), W'(a0)};
  endfunction

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] w,
                              input logic [4*W-1:0] a, input logic [4*W-1:0] d,
                              input logic [3:0] eg, input logic [3:0] ev,
                              input logic [4*W-1:0] er);
    vec_t v;
    v.req = r; v.we = w; v.addr = a; v.wdata = d;
    v.e_gnt = eg; v.e_rv = ev; v.e_rd = er;
    return v;
  endfunction

  task automatic apply_vec(input vec_t v, input string tag);
    @(negedge clk);
    req = v.req; we_req = v.we; addr_req = v.addr; wdata_req = v.wdata;
    #1;
    chk({tag, " gnt"}, gnt, v.e_gnt);
    @(posedge clk);
    #1;
    chk({tag, " rvalid"}, rvalid, v.e_rv);
    for (int i = 0; i < 4; i++)
      if (v.e_rv[i]) chk($sformatf("%s rdata%0d", tag, i), rdata[i*W +: W], v.e_rd[i*W +: W]);
  endtask

  // Called with rst high; releases it and checks every INIT cycle.
  task automatic run_init(input string tag);
    @(negedge clk);
    rst = 1'b0;
    req = 4'hF; we_req = 4'h0;
    for (int c = 0; c < M/2; c++) begin
      #1;
      chk($sformatf("%s init_done c%0d", tag, c), init_done, 1'b0);
      chk($sformatf("%s we c%0d", tag, c), {we_x, we_y}, 2'b11);
      chk($sformatf("%s addr_x c%0d", tag, c), addr_x, 2*c);
      chk($sformatf("%s addr_y c%0d", tag, c), addr_y, 2*c+1);
      chk($sformatf("%s data c%0d", tag, c), {data_x, data_y}, 0);
      chk($sformatf("%s gnt c%0d", tag, c), gnt, 4'h0);
      @(negedge clk);
    end
    req = 4'h0;
    #1;
    chk({tag, " init_done end"}, init_done, 1'b1);
  endtask

  vec_t tbl [12];

  // Reference model state for the random phase.
  int           mptr;
  logic [W-1:0] mmem [M];
  logic [3:0]   pend, pwe;
  logic [W-1:0] paddr [4];
  logic [W-1:0] pdata [4];

  initial begin
    tbl[0]  = mk(4'b0001, 4'b0001, pk(0,0,0,3), pk(0,0,0,'hA5), 4'b0001, 4'b0000, '0);
    tbl[1]  = mk(4'b0001, 4'b0000, pk(0,0,0,3), '0,             4'b0001, 4'b0001, pk(0,0,0,'hA5));
    tbl[2]  = mk(4'b0110, 4'b0010, pk(0,5,5,0), pk(0,0,'h3C,0), 4'b0010, 4'b0000, '0);
    tbl[3]  = mk(4'b0100, 4'b0000, pk(0,5,0,0), '0,             4'b0100, 4'b0100, pk(0,'h3C,0,0));
    tbl[4]  = mk(4'b1001, 4'b0000, pk(7,0,0,7), '0,             4'b1001, 4'b1001, pk(0,0,0,0));
    tbl[5]  = mk(4'b1111, 4'b0000, pk(3,7,5,3), '0,             4'b0110, 4'b0110, pk(0,0,'h3C,0));
    tbl[6]  = mk(4'b1111, 4'b0000, pk(3,7,5,3), '0,             4'b1001, 4'b1001, pk('hA5,0,0,'hA5));
    tbl[7]  = mk(4'b1111, 4'b0000, pk(3,7,5,3), '0,             4'b0110, 4'b0110, pk(0,0,'h3C,0));
    tbl[8]  = mk(4'b0000, 4'b0000, '0,          '0,             4'b0000, 4'b0000, '0);
    tbl[9]  = mk(4'b1001, 4'b1001, pk(0,0,0,0), pk('h11,0,0,'h22), 4'b1000, 4'b0000, '0);
    tbl[10] = mk(4'b0001, 4'b0001, pk(0,0,0,0), pk(0,0,0,'h22), 4'b0001, 4'b0000, '0);
    tbl[11] = mk(4'b0100, 4'b0000, pk(0,0,0,0), '0,             4'b0100, 4'b0100, pk(0,'h22,0,0));

    rst = 1'b1; ram_scrub = 1'b1;
    req = 4'h0; we_req = 4'h0; addr_req = '0; wdata_req = '0;
    repeat (2) @(negedge clk);
    ram_scrub = 1'b0;
    req = 4'hF;
    #1;
    chk("reset init_done", init_done, 1'b0);
    chk("reset gnt", gnt, 4'h0);
    chk("reset rvalid", rvalid, 4'h0);
    chk("reset we", {we_x, we_y}, 2'b11);
    chk("reset addr_x", addr_x, 0);

    run_init("init1");

    for (int t = 0; t < 12; t++) apply_vec(tbl[t], $sformatf("vec%0d", t));

    // Reset lands right after a read grant: the read must never complete.
    @(negedge clk);
    req = 4'b0001; we_req = 4'b0000; addr_req = pk(0,0,0,3);
    #1;
    chk("midrst gnt", gnt, 4'b0001);
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = 4'h0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("midrst rvalid c%0d", c), rvalid, 4'h0);
      chk($sformatf("midrst init_done c%0d", c), init_done, 1'b0);
      @(negedge clk);
    end
    run_init("init2");
    @(negedge clk);
    #1;
    chk("post-init rvalid", rvalid, 4'h0);

    mptr = 0;
    for (int j = 0; j < M; j++) mmem[j] = '0;
    pend = 4'h0; pwe = 4'h0;
    for (int i = 0; i < 4; i++) begin paddr[i] = '0; pdata[i] = '0; end

    for (int cyc = 0; cyc < 400; cyc++) begin
      int           order [$];
      int           first, second;
      logic [3:0]   egnt, erv;
      logic [4*W-1:0] erd;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]  = 1'b1;
          pwe[i]   = ($urandom_range(0, 2) == 0);
          paddr[i] = W'($urandom_range(0, 7));
          pdata[i] = W'($urandom);
        end
      end
      req = pend; we_req = pwe;
      addr_req  = {paddr[3], paddr[2], paddr[1], paddr[0]};
      wdata_req = {pdata[3], pdata[2], pdata[1], pdata[0]};

      order.delete();
      for (int k = 0; k < 4; k++)
        if (pend[(mptr + k) % 4]) order.push_back((mptr + k) % 4);
      first = -1; second = -1;
      if (order.size() > 0) begin
        first = order[0];
        for (int n = 1; n < order.size(); n++) begin
          if (second < 0 && !(paddr[order[n]] == paddr[first] && (pwe[order[n]] || pwe[first])))
            second = order[n];
        end
      end
      egnt = 4'h0; erv = 4'h0; erd = '0;
      if (first >= 0)  egnt[first]  = 1'b1;
      if (second >= 0) egnt[second] = 1'b1;
      for (int i = 0; i < 4; i++)
        if (egnt[i] && !pwe[i]) begin
          erv[i] = 1'b1;
          erd[i*W +: W] = mmem[paddr[i]];
        end
      #1;
      chk($sformatf("rnd%0d gnt", cyc), gnt, egnt);
      for (int i = 0; i < 4; i++)
        if (egnt[i]) begin
          if (pwe[i]) mmem[paddr[i]] = pdata[i];
          pend[i] = 1'b0;
        end
      if (second >= 0)     mptr = (second + 1) % 4;
      else if (first >= 0) mptr = (first + 1) % 4;
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d rvalid", cyc), rvalid, erv);
      for (int i = 0; i < 4; i++)
        if (erv[i]) chk($sformatf("rnd%0d rdata%0d", cyc, i), rdata[i*W +: W], erd[i*W +: W]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
